// File: rtl/andg_unit.sv
// Registered bitwise AND with an all-ones reduction flag and a valid qualifier.
// The pipeline depth is set by STAGES. The datapath always advances and is not gated by in_valid.
module andg_unit #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] c,
   output logic             c_all
);

   logic [WIDTH-1:0] and_d;

   assign and_d = a & b;

   if (STAGES == 1) begin : g_single
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            data_q  <= and_d;
            valid_q <= in_valid;
         end
      end

      assign c         = data_q;
      assign out_valid = valid_q;
   end else begin : g_multi
      // Index 0 holds the newest capture and index STAGES-1 feeds the outputs.
      logic [STAGES-1:0][WIDTH-1:0] data_q;
      logic [STAGES-1:0]            valid_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
         end else begin
            data_q  <= {data_q[STAGES-2:0], and_d};
            valid_q <= {valid_q[STAGES-2:0], in_valid};
         end
      end

      assign c         = data_q[STAGES-1];
      assign out_valid = valid_q[STAGES-1];
   end

   // c_all is taken from the output register, so it always matches c.
   assign c_all = &c;

endmodule

// File: tb/tb_andg_unit.sv
// Scoreboard bench for andg_unit. One instance is 1-bit wide with 1 stage; the other is 8-bit wide with 3 stages.
// Expected results are queued when stimulus is driven and popped once the pipeline latency has elapsed.
module tb_andg_unit;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       v1, a1, b1;
   logic       ov1, c1, call1;
   logic       v8;
   logic [7:0] a8, b8;
   logic       ov8, call8;
   logic [7:0] c8;

   int vectors;
   int miscompares;
   exp_t q1[$];
   exp_t q8[$];

   andg_unit #(.WIDTH(1), .STAGES(1)) u_w1 (
      .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1),
      .out_valid(ov1), .c(c1), .c_all(call1)
   );

   andg_unit #(.WIDTH(8), .STAGES(3)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8),
      .out_valid(ov8), .c(c8), .c_all(call8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ov1"},   {7'b0, ov1},   8'h00);
      chk({tag, "_c1"},    {7'b0, c1},    8'h00);
      chk({tag, "_call1"}, {7'b0, call1}, 8'h00);
      chk({tag, "_ov8"},   {7'b0, ov8},   8'h00);
      chk({tag, "_c8"},    c8,            8'h00);
      chk({tag, "_call8"}, {7'b0, call8}, 8'h00);
   endtask

   // Called after each rising edge. Until a queue holds STAGES entries, the outputs still show the reset contents.
   task automatic check_outputs(input string tag);
      exp_t e;
      e = '0;
      if (q1.size() >= 1) e = q1.pop_front();
      chk({tag, "_ov1"},   {7'b0, ov1},   {7'b0, e.v});
      chk({tag, "_c1"},    {7'b0, c1},    e.d);
      chk({tag, "_call1"}, {7'b0, call1}, {7'b0, e.d[0]});
      e = '0;
      if (q8.size() >= 3) e = q8.pop_front();
      chk({tag, "_ov8"},   {7'b0, ov8},   {7'b0, e.v});
      chk({tag, "_c8"},    c8,            e.d);
      chk({tag, "_call8"}, {7'b0, call8}, {7'b0, &e.d});
   endtask

   task automatic step(input string tag,
                       input logic vv1, input logic aa1, input logic bb1,
                       input logic vv8, input logic [7:0] aa8, input logic [7:0] bb8);
      @(negedge clk);
      v1 = vv1; a1 = aa1; b1 = bb1;
      v8 = vv8; a8 = aa8; b8 = bb8;
      q1.push_back('{v: vv1, d: {7'b0, aa1 & bb1}});
      q8.push_back('{v: vv8, d: aa8 & bb8});
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      #1;
      chk_zero("por");
      repeat (2) @(posedge clk);
      #1;
      chk_zero("por_held");
      @(negedge clk);
      rst = 1'b0;

      // u_w1 walks the truth table. u_w8 runs the pattern 1,1,0,1,1.
      step("tt01", 1'b1, 1'b0, 1'b1, 1'b1, 8'hF0, 8'h3C);
      step("tt11", 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
      step("tt00", 1'b1, 1'b0, 1'b0, 1'b0, 8'h13, 8'h37);
      step("tt10", 1'b1, 1'b1, 1'b0, 1'b1, 8'h0A, 8'h0F);
      step("thr5", 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3, 8'hFF);
      repeat (3) step("drain", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      // A single valid pulse must emerge exactly once, two edges after capture.
      step("lat_pre", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      step("lat_cap", 1'b1, 1'b1, 1'b1, 1'b1, 8'h0A, 8'h0F);
      repeat (4) step("lat_post", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      // Two operations are still in flight when rst is pulsed asynchronously between edges.
      step("mid_op1", 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 8'hFF);
      step("mid_op2", 1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 8'h81);
      @(negedge clk);
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
      v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      #2;
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      q1.delete();
      q8.delete();
      @(posedge clk);
      #1;
      chk_zero("rst_edge");
      @(negedge clk);
      rst = 1'b0;
      v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      repeat (4) step("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      step("resume", 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 8'h0F);
      repeat (3) step("resume_drain", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      for (int i = 0; i < 24; i++) begin
         logic [7:0] ra, rb;
         logic [2:0] rv;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rv = 3'($urandom);
         step("rand", rv[0], ra[0], rb[0], rv[1], ra, (rv[2] ? 8'hFF : rb));
      end
      repeat (3) step("final_drain", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
